// File: rtl/div_iter32_if.sv
// Handshake/operand bundle for the iterative divider.
interface div_iter32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       fsel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] q;

    modport master (
        output start,
        output fsel,
        output a,
        output b,
        output cancel,
        input  busy,
        input  ready,
        input  q
    );

    modport slave (
        input  start,
        input  fsel,
        input  a,
        input  b,
        input  cancel,
        output busy,
        output ready,
        output q
    );
endinterface

// File: rtl/div_iter32.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional feature: DIV_EARLY_OUT_EN (divide-by-zero / signed overflow skip CALC).
module div_iter32 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        clrn,
    div_iter32_if.slave dif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             rem_sel_q, rem_sel_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
`ifdef DIV_EARLY_OUT_EN
    logic             early_q, early_d;
    logic             special;
    logic             ovf;
`endif

    logic             op_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             done_ok;

    // |MIN| stays as unsigned 2^(WIDTH-1); the extra trial bit absorbs it
    always_comb begin : operand_abs
        op_signed = ~dif.fsel[0];
        a_abs     = dif.a;
        b_abs     = dif.b;
        if (op_signed && dif.a[WIDTH-1]) a_abs = -dif.a;
        if (op_signed && dif.b[WIDTH-1]) b_abs = -dif.b;
    end

`ifdef DIV_EARLY_OUT_EN
    always_comb begin : special_detect
        ovf     = op_signed
                  && (dif.a == {1'b1, {(WIDTH-1){1'b0}}})
                  && (dif.b == {WIDTH{1'b1}});
        special = (dif.b == '0) || ovf;
    end
`endif

    always_comb begin : trial_sub
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_comb begin : result_sel
        res = quo_q;
        if (rem_sel_q) begin
            res = neg_rem_q ? -rem_q : rem_q;
        end else if (neg_quo_q && !b_zero_q) begin
            res = -quo_q;
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        hold_d    = hold_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
`ifdef DIV_EARLY_OUT_EN
        early_d   = early_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (dif.start && !dif.cancel) begin
                    rem_sel_d = dif.fsel[1];
                    neg_quo_d = op_signed
                                & (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
                    neg_rem_d = op_signed & dif.a[WIDTH-1];
                    b_zero_d  = (dif.b == '0);
                    dvs_d     = b_abs;
                    rem_d     = '0;
                    quo_d     = a_abs;
                    cnt_d     = CW'(WIDTH);
                    state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    early_d   = 1'b0;
                    // Preload what the full iteration would have produced
                    if (special) begin
                        early_d = 1'b1;
                        state_d = S_DONE;
                        cnt_d   = '0;
                        if (dif.b == '0) begin
                            quo_d = '1;
                            rem_d = a_abs;
                        end else begin
                            quo_d = {1'b1, {(WIDTH-1){1'b0}}};
                            rem_d = '0;
                        end
                    end
`endif
                end
            end
            S_CALC: begin
                if (dif.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!dif.cancel) hold_d = res;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done_ok   = (state_q == S_DONE) && !dif.cancel;
    assign dif.ready = done_ok;
    assign dif.q     = done_ok ? res : hold_q;
`ifdef DIV_EARLY_OUT_EN
    assign dif.busy  = (state_q == S_CALC)
                       || ((state_q == S_DONE) && !early_q);
`else
    assign dif.busy  = (state_q != S_IDLE);
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            hold_q    <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            hold_q    <= hold_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
`ifdef DIV_EARLY_OUT_EN
            early_q   <= early_d;
`endif
        end
    end

endmodule

// File: tb/tb_div_iter32.sv
// Randomized self-checking bench for div_iter32 against an arithmetic model.
module tb_div_iter32;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic clrn;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_q;

    always #5 clk = ~clk;

    div_iter32_if dif ();

    div_iter32 dut (
        .clk  (clk),
        .clrn (clrn),
        .dif  (dif)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] fsel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return fsel[1] ? a : 32'hFFFF_FFFF;
        if (!fsel[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return fsel[1] ? 32'd0 : 32'h8000_0000;
            return fsel[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return fsel[1] ? (a % b) : (a / b);
    endfunction

    function automatic int exp_lat(input logic [1:0] fsel,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 32'd0)
                  || (!fsel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (EARLY && special) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic launch(input logic [1:0] fsel, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        dif.start = 1'b1;
        dif.fsel  = fsel;
        dif.a     = a;
        dif.b     = b;
        @(posedge clk);
        #1 dif.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] fsel,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        int lat;
        int rdy_at;
        int rdy_n;
        int busy_n;
        logic [31:0] exp;
        logic [31:0] q_at;
        exp    = ref_div(fsel, a, b);
        lat    = exp_lat(fsel, a, b);
        rdy_at = 0;
        rdy_n  = 0;
        busy_n = 0;
        q_at   = 32'hDEAD_BEEF;
        launch(fsel, a, b);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (dif.busy) busy_n++;
            if (dif.ready) begin
                rdy_n++;
                if (rdy_at == 0) rdy_at = n;
                q_at = dif.q;
            end
            dif.start = noise && (n == lat || (lat > 1 && (n == 5 || n == 20)));
            if (dif.start) begin
                dif.a    = $urandom;
                dif.b    = $urandom;
                dif.fsel = 2'($urandom);
            end
        end
        check({tag, " ready_cycle"}, 32'(rdy_at), 32'(lat));
        check({tag, " ready_pulses"}, 32'(rdy_n), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), (lat == 1) ? 32'd0 : 32'(lat));
        check({tag, " q"}, q_at, exp);
        check({tag, " q_hold"}, dif.q, exp);
        last_q = exp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_n;
        int busy_n;
        dif.start  = 1'b0;
        dif.cancel = 1'b0;
        dif.fsel   = 2'b00;
        dif.a      = 32'd0;
        dif.b      = 32'd0;
        last_q     = 32'd0;
        clrn       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(dif.busy), 32'd0);
        check("reset ready", 32'(dif.ready), 32'd0);
        check("reset q", dif.q, 32'd0);
        clrn = 1'b1;

        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div 5/0", 2'b00, 32'd5, 32'd0, 1'b0);
        run_op("rem -5/0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("remu x/0", 2'b11, 32'h8000_0001, 32'd0, 1'b0);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("divu noise", 2'b01, 32'h1234_5678, 32'h0000_0321, 1'b1);
        run_op("div0 noise", 2'b00, 32'hFFFF_FF00, 32'd0, 1'b1);

        // cancel during CALC with start held high
        rdy_n = 0;
        launch(2'b01, 32'd1000, 32'd3);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (dif.ready) rdy_n++;
        end
        @(negedge clk);
        dif.cancel = 1'b1;
        dif.start  = 1'b1;
        #1;
        if (dif.ready) rdy_n++;
        check("cancel calc q", dif.q, last_q);
        @(negedge clk);
        dif.cancel = 1'b0;
        dif.start  = 1'b0;
        check("cancel calc busy", 32'(dif.busy), 32'd0);
        check("cancel calc ready", 32'(rdy_n), 32'd0);
        run_op("post cancel", 2'b01, 32'd100, 32'd7, 1'b0);

        // cancel in the DONE cycle
        rdy_n = 0;
        launch(2'b01, 32'd1000, 32'd3);
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (dif.ready) rdy_n++;
        end
        @(negedge clk);
        dif.cancel = 1'b1;
        #1;
        if (dif.ready) rdy_n++;
        check("cancel done ready", 32'(rdy_n), 32'd0);
        check("cancel done q", dif.q, last_q);
        @(negedge clk);
        dif.cancel = 1'b0;
        check("cancel done busy", 32'(dif.busy), 32'd0);
        check("cancel done q2", dif.q, last_q);

        // asynchronous reset mid-divide
        launch(2'b00, 32'hFFFF_FC18, 32'd7);
        for (int n = 1; n <= 19; n++) @(negedge clk);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("midrst busy", 32'(dif.busy), 32'd0);
        check("midrst ready", 32'(dif.ready), 32'd0);
        check("midrst q", dif.q, 32'd0);
        @(negedge clk);
        clrn   = 1'b1;
        last_q = 32'd0;
        rdy_n  = 0;
        busy_n = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dif.ready) rdy_n++;
            if (dif.busy) busy_n++;
        end
        check("post rst ready", 32'(rdy_n), 32'd0);
        check("post rst busy", 32'(busy_n), 32'd0);
        check("post rst q", dif.q, 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom), pick(), pick(),
                   ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
